turtle_boot_loader: RTL and testbench
=====================================

Name: turtle_boot_loader

Overview:
Boot/load sequencer for the Turtle CPU core. It holds the core in reset and accepts a byte stream over a valid/ready handshake. Bytes are packed little-endian into INST_W-wide instructions and written sequentially into instruction memory from byte address 0. After the last byte, the core is released after a programmable delay. The block sits beside turtle_cpu_core and drives the core's reset_n and the instruction-memory write port.

Parameters:
INST_W, 16, instruction width in bits; must be a multiple of 8
I_ADDR_W, 12, instruction byte-address width; matches the core
RELEASE_DELAY, 2, cycles spent in RELEASE before core_reset_n deasserts; minimum 1
localparam INST_W_BYTES = INST_W/8; localparam MAX_INST = 2**I_ADDR_W / INST_W_BYTES

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  begin a load; ignored outside IDLE and RUN
halt  input  1  in RUN: return to IDLE with the core held in reset
load_valid  input  1  load_data is valid
load_ready  output  1  the block accepts a byte this cycle
load_data  input  8  stream byte
load_last  input  1  marks the final byte of the image; qualified by load_valid
imem_we  output  1  one-cycle instruction-memory write strobe
imem_waddr  output  I_ADDR_W  byte address of the word being written
imem_wdata  output  INST_W  packed instruction
core_reset_n  output  1  drives the core's reset_n; low in every state except RUN
running  output  1  high in RUN
load_error  output  1  sticky overflow flag; cleared on reset or on start

Behaviour:
- All outputs are registered except load_ready, which is decoded from state.
- Reset values: state IDLE; load_ready 0, imem_we 0, imem_waddr 0, imem_wdata 0, core_reset_n 0, running 0, load_error 0; byte index 0, word address 0. A reset asserted mid-load aborts the load immediately; words already written stay in memory.
- IDLE: waits for start, then goes to LOAD. On that transition, word address, byte index and load_error clear.
- LOAD: load_ready=1. Byte accepted when load_valid && load_ready. Byte k of a word (k = 0..INST_W_BYTES-1) goes to bits [8k+7:8k].
- On acceptance of the byte that completes a word, the next cycle has imem_we=1, imem_wdata=the assembled word, imem_waddr=the current word address. The word address then advances by INST_W_BYTES. Write latency from final byte accepted to strobe is 1 cycle.
- load_last accepted on a partial word: remaining upper bytes pad with 0x00, the word is written next cycle, and the state goes to RELEASE. load_last completing a word: write the word, then go to RELEASE.
- Overflow: once MAX_INST words are written, further bytes are still accepted but dropped (no imem_we) and load_error sets. imem_waddr does not wrap.
- RELEASE: a counter runs RELEASE_DELAY cycles with core_reset_n=0, then the state goes to RUN. RELEASE is entered even when load_error=1.
- RUN: core_reset_n=1, running=1. halt goes to IDLE (core_reset_n=0 next cycle). start goes directly to LOAD (reload: core reset next cycle, counters cleared). halt and start asserted together: halt wins.
- start in LOAD or RELEASE is ignored.

Optional Feature:
BOOT_CHECKSUM_EN
- Defined: the load_last byte is a checksum byte and is not written to memory. An 8-bit running sum of all accepted bytes, including the checksum byte, must equal 0x00 modulo 256.
  - On mismatch: go to IDLE instead of RELEASE, set load_error, core stays in reset.
  - A pending partial word is still padded and written before the check completes.
  - Adds output checksum_ok (1 bit), reset 0, set when the check passes.
- Not defined: load_last byte is ordinary data; no checksum logic; no checksum_ok port.

Test Plan:
- Reset, start, then bytes 0x34,0x12,0x78,0x56(last) -> imem_we pulses write 0x1234@0x000 and 0x5678@0x002. After RELEASE_DELAY=2 cycles core_reset_n=1 and running=1.
- Odd byte count: 0xAB,0xCD,0xEF(last) -> writes 0xCDAB@0x000 and 0x00EF@0x002.
- load_valid toggled every other cycle, with start and halt pulsed during LOAD -> identical writes to the gapless case; start and halt ignored.
- In RUN, pulse halt -> core_reset_n=0 and running=0 next cycle, state IDLE. Then start and a 2-byte image -> word rewritten @0x000.
- Stream 4098 bytes (I_ADDR_W=12) -> 2048 writes, last @0xFFE; load_error=1; no write for the extra bytes; core still released.
- reset asserted mid-word after 1 byte -> all outputs return to reset values next cycle; no imem_we. With BOOT_CHECKSUM_EN: bytes 0x10,0x20,0xD0(last) -> checksum_ok=1, released. Last byte 0xD1 -> load_error=1, IDLE, core_reset_n stays 0.

Source files
------------

// File: rtl/turtle_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : turtle_boot_loader
// Brief    : Holds the Turtle core in reset, packs a byte stream into
//            instructions, writes them to imem, then releases the core.
//            Optional BOOT_CHECKSUM_EN: last byte is a zero-sum checksum.
// Revision : 1.0 - initial release
// ============================================================================
module turtle_boot_loader #(
    parameter int INST_W        = 16,
    parameter int I_ADDR_W      = 12,
    parameter int RELEASE_DELAY = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                halt,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [7:0]          load_data,
    input  logic                load_last,
    output logic                imem_we,
    output logic [I_ADDR_W-1:0] imem_waddr,
    output logic [INST_W-1:0]   imem_wdata,
    output logic                core_reset_n,
    output logic                running,
    output logic                load_error
`ifdef BOOT_CHECKSUM_EN
    ,
    output logic                checksum_ok
`endif
);

    localparam int c_INST_BYTES = INST_W / 8;
    localparam int c_MAX_INST   = (2 ** I_ADDR_W) / c_INST_BYTES;
    localparam int c_IDX_W      = (c_INST_BYTES > 1) ? $clog2(c_INST_BYTES) : 1;
    localparam int c_CNT_W      = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY + 1) : 1;

    localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(c_INST_BYTES - 1);
    localparam logic [I_ADDR_W-1:0] c_ADDR_STEP = I_ADDR_W'(c_INST_BYTES);
    localparam logic [I_ADDR_W-1:0] c_LAST_ADDR = I_ADDR_W'((c_MAX_INST - 1) * c_INST_BYTES);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST  = c_CNT_W'(RELEASE_DELAY - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_IDX_W-1:0]  r_idx;
    logic [I_ADDR_W-1:0] r_addr;
    logic [INST_W-1:0]   r_buf;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_full;

    logic                w_accept;
    logic                w_complete;
    logic [INST_W-1:0]   w_buf_next;
    logic [INST_W-1:0]   w_word;

`ifdef BOOT_CHECKSUM_EN
    logic [7:0]          r_sum;
    logic [7:0]          w_sum;
`endif

    assign load_ready = (r_state == ST_LOAD);

    always_comb begin
        w_accept   = load_valid && load_ready;
        w_buf_next = r_buf;
        for (int k = 0; k < c_INST_BYTES; k++) begin
            if (r_idx == c_IDX_W'(k)) begin
                w_buf_next[8*k +: 8] = load_data;
            end
        end
`ifdef BOOT_CHECKSUM_EN
        // The checksum byte never lands in memory; it only flushes a partial word.
        w_word     = load_last ? r_buf : w_buf_next;
        w_complete = load_last ? (r_idx != '0) : (r_idx == c_IDX_LAST);
        w_sum      = r_sum + load_data;
`else
        w_word     = w_buf_next;
        w_complete = load_last || (r_idx == c_IDX_LAST);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_addr       <= '0;
            r_buf        <= '0;
            r_cnt        <= '0;
            r_full       <= 1'b0;
            imem_we      <= 1'b0;
            imem_waddr   <= '0;
            imem_wdata   <= '0;
            core_reset_n <= 1'b0;
            running      <= 1'b0;
            load_error   <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            r_sum        <= '0;
            checksum_ok  <= 1'b0;
`endif
        end else begin
            imem_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_LOAD;
                        r_idx      <= '0;
                        r_addr     <= '0;
                        r_buf      <= '0;
                        r_full     <= 1'b0;
                        load_error <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
                        r_sum       <= '0;
                        checksum_ok <= 1'b0;
`endif
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        // Memory full: keep draining the stream but flag it.
                        if (r_full) begin
                            load_error <= 1'b1;
                        end
                        if (w_complete) begin
                            r_buf <= '0;
                            r_idx <= '0;
                            if (!r_full) begin
                                imem_we    <= 1'b1;
                                imem_wdata <= w_word;
                                imem_waddr <= r_addr;
                                r_addr     <= r_addr + c_ADDR_STEP;
                                r_full     <= (r_addr == c_LAST_ADDR);
                            end
                        end else begin
                            r_buf <= w_buf_next;
                            r_idx <= r_idx + c_IDX_W'(1);
                        end
`ifdef BOOT_CHECKSUM_EN
                        r_sum <= w_sum;
                        if (load_last) begin
                            if (w_sum == 8'h00) begin
                                checksum_ok <= 1'b1;
                                r_state     <= ST_RELEASE;
                                r_cnt       <= '0;
                            end else begin
                                load_error <= 1'b1;
                                r_state    <= ST_IDLE;
                            end
                        end
`else
                        if (load_last) begin
                            r_state <= ST_RELEASE;
                            r_cnt   <= '0;
                        end
`endif
                    end
                end
                ST_RELEASE: begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_state      <= ST_RUN;
                        core_reset_n <= 1'b1;
                        running      <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (halt) begin
                        r_state      <= ST_IDLE;
                        core_reset_n <= 1'b0;
                        running      <= 1'b0;
                    end else if (start) begin
                        r_state      <= ST_LOAD;
                        core_reset_n <= 1'b0;
                        running      <= 1'b0;
                        r_idx        <= '0;
                        r_addr       <= '0;
                        r_buf        <= '0;
                        r_full       <= 1'b0;
                        load_error   <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
                        r_sum       <= '0;
                        checksum_ok <= 1'b0;
`endif
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_turtle_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_turtle_boot_loader
// Brief    : Directed + randomized self-checking bench for turtle_boot_loader.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_turtle_boot_loader;

    localparam int INST_W        = 16;
    localparam int I_ADDR_W      = 12;
    localparam int RELEASE_DELAY = 2;
    localparam int B             = INST_W / 8;
    localparam int MAX_INST      = (2 ** I_ADDR_W) / B;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic                halt;
    logic                load_valid;
    logic                load_ready;
    logic [7:0]          load_data;
    logic                load_last;
    logic                imem_we;
    logic [I_ADDR_W-1:0] imem_waddr;
    logic [INST_W-1:0]   imem_wdata;
    logic                core_reset_n;
    logic                running;
    logic                load_error;
`ifdef BOOT_CHECKSUM_EN
    logic                checksum_ok;
`endif

    int         checks     = 0;
    int         failures   = 0;
    int         wr_count   = 0;
    int         wr_base    = 0;
    int         exp_writes = 0;
    logic [7:0] img[$];

    always #5 clk = ~clk;

    turtle_boot_loader #(
        .INST_W        (INST_W),
        .I_ADDR_W      (I_ADDR_W),
        .RELEASE_DELAY (RELEASE_DELAY)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .halt         (halt),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_data    (load_data),
        .load_last    (load_last),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .core_reset_n (core_reset_n),
        .running      (running),
        .load_error   (load_error)
`ifdef BOOT_CHECKSUM_EN
        ,
        .checksum_ok  (checksum_ok)
`endif
    );

    always @(negedge clk) begin
        if (imem_we === 1'b1) wr_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Little-endian word w of the image's first d data bytes, zero padded.
    function automatic logic [31:0] exp_word(input int w, input int d);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < B; k++) begin
            if (w * B + k < d) r[8*k +: 8] = img[w * B + k];
        end
        return r;
    endfunction

    task automatic seal_image();
`ifdef BOOT_CHECKSUM_EN
        logic [7:0] s;
        s = 8'h00;
        foreach (img[i]) s = s + img[i];
        img.push_back(8'h00 - s);
`endif
    endtask

    task automatic random_image(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back(8'($urandom));
        seal_image();
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_image(input bit gaps, input bit csum_good);
        int n, d, widx;
        bit wr;
        n = img.size();
        d = n;
`ifdef BOOT_CHECKSUM_EN
        d = n - 1;
`endif
        exp_writes = (d + B - 1) / B;
        if (exp_writes > MAX_INST) exp_writes = MAX_INST;
        wr_base = wr_count;
        for (int i = 0; i < n; i++) begin
            if (gaps && (i % 2 == 1)) begin
                load_valid = 1'b0;
                start      = (i % 4 == 1);
                halt       = (i % 4 == 3);
                @(negedge clk);
                start = 1'b0;
                halt  = 1'b0;
            end
            load_valid = 1'b1;
            load_data  = img[i];
            load_last  = (i == n - 1);
            check("load_ready", load_ready, 1);
            @(negedge clk);
            widx = ((i < d) ? i : d - 1) / B;
            wr   = (((i % B) == B - 1 && i < d) || (i == n - 1 && (d % B) != 0)) && widx < MAX_INST;
            check("imem_we", imem_we, wr);
            if (wr) begin
                check("imem_waddr", imem_waddr, widx * B);
                check("imem_wdata", imem_wdata, exp_word(widx, d));
            end
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        check("load_error", load_error, (n > MAX_INST * B) || !csum_good);
    endtask

    task automatic expect_release();
        check("rel_core_reset_n", core_reset_n, 0);
        repeat (RELEASE_DELAY - 1) @(negedge clk);
        check("rel_running", running, 0);
        @(negedge clk);
        check("run_running", running, 1);
        check("run_core_reset_n", core_reset_n, 1);
        check("run_load_ready", load_ready, 0);
    endtask

    task automatic check_count();
        check("write_count", wr_count - wr_base, exp_writes);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        halt       = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h00;
        load_last  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_load_ready", load_ready, 0);
        check("rst_imem_we", imem_we, 0);
        check("rst_imem_waddr", imem_waddr, 0);
        check("rst_imem_wdata", imem_wdata, 0);
        check("rst_core_reset_n", core_reset_n, 0);
        check("rst_running", running, 0);
        check("rst_load_error", load_error, 0);
`ifdef BOOT_CHECKSUM_EN
        check("rst_checksum_ok", checksum_ok, 0);
`endif
        reset = 1'b0;
        @(negedge clk);
        check("idle_load_ready", load_ready, 0);

        // Basic 4-byte image.
        do_start();
        check("load_entered", load_ready, 1);
        img = '{8'h34, 8'h12, 8'h78, 8'h56};
        seal_image();
        send_image(1'b0, 1'b1);
        expect_release();
        check_count();
        check("t1_last_wdata", imem_wdata, 32'h5678);
        check("t1_last_waddr", imem_waddr, 32'h002);

        // Halt from RUN, then reload a 2-byte image from IDLE.
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        check("halt_core_reset_n", core_reset_n, 0);
        check("halt_running", running, 0);
        check("halt_idle", load_ready, 0);
        @(negedge clk);
        check("halt_stays_idle", load_ready, 0);
        do_start();
        random_image(2);
        send_image(1'b0, 1'b1);
        expect_release();
        check_count();

        // Reload directly from RUN with an odd byte count.
        do_start();
        check("reload_core_reset_n", core_reset_n, 0);
        check("reload_running", running, 0);
        check("reload_load_ready", load_ready, 1);
        img = '{8'hAB, 8'hCD, 8'hEF};
        seal_image();
        send_image(1'b0, 1'b1);
        expect_release();
        check_count();
        check("odd_last_wdata", imem_wdata, 32'h00EF);
        check("odd_last_waddr", imem_waddr, 32'h002);

        // Gapped stream with start/halt pulses that LOAD must ignore.
        do_start();
        random_image($urandom_range(5, 20));
        send_image(1'b1, 1'b1);
        expect_release();
        check_count();

        // halt and start together in RUN: halt wins.
        halt  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        halt  = 1'b0;
        start = 1'b0;
        check("both_idle", load_ready, 0);
        check("both_core_reset_n", core_reset_n, 0);

        // Random images of assorted lengths.
        for (int t = 0; t < 3; t++) begin
            do_start();
            random_image($urandom_range(1, 9));
            send_image(1'b0, 1'b1);
            expect_release();
            check_count();
        end

        // Overflow: two bytes past the full instruction memory.
        do_start();
        random_image(MAX_INST * B + 2);
        send_image(1'b0, 1'b1);
        expect_release();
        check_count();
        check("ovf_last_waddr", imem_waddr, 32'hFFE);
        check("ovf_load_error_held", load_error, 1);

        // Reset mid-word after one byte.
        do_start();
        check("start_clears_error", load_error, 0);
        wr_base    = wr_count;
        load_valid = 1'b1;
        load_data  = 8'($urandom);
        load_last  = 1'b0;
        @(negedge clk);
        load_valid = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        check("mid_imem_we", imem_we, 0);
        check("mid_imem_waddr", imem_waddr, 0);
        check("mid_imem_wdata", imem_wdata, 0);
        check("mid_core_reset_n", core_reset_n, 0);
        check("mid_running", running, 0);
        check("mid_load_error", load_error, 0);
        check("mid_load_ready", load_ready, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_no_write", wr_count - wr_base, 0);
        check("mid_idle", load_ready, 0);

`ifdef BOOT_CHECKSUM_EN
        // Good checksum: 0x10+0x20+0xD0 wraps to zero.
        do_start();
        img = '{8'h10, 8'h20, 8'hD0};
        send_image(1'b0, 1'b1);
        check("csum_ok", checksum_ok, 1);
        expect_release();
        check_count();
        check("csum_wdata", imem_wdata, 32'h2010);

        // Bad checksum: back to IDLE with the core held in reset.
        do_start();
        img = '{8'h10, 8'h20, 8'hD1};
        send_image(1'b0, 1'b0);
        check("csum_bad_ok", checksum_ok, 0);
        repeat (RELEASE_DELAY + 2) @(negedge clk);
        check("csum_bad_core_reset_n", core_reset_n, 0);
        check("csum_bad_running", running, 0);
        check("csum_bad_idle", load_ready, 0);
        check("csum_bad_error", load_error, 1);
        check_count();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
